// File: rtl/multicycle_control.sv
// Multicycle RV32 subset control unit: Moore FSM sequencing fetch, decode,
// execute, memory and write-back, with a memory-wait watchdog that traps.
module multicycle_control #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       alu_zero,
   input  logic       alu_lt,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_sel,
   output logic [2:0] imm_sel,
   output logic       alu_src_b,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       fault
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      TRAP
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state, state_next;
   logic [7:0] cnt, cnt_next;
   logic [6:0] op_q;
   logic [1:0] br_q;   // {funct3[2], funct3[0]}: selects zero/lt and polarity
   logic       taken;

   function automatic logic [2:0] imm_of(input logic [6:0] op);
      case (op)
         OP_STORE:  imm_of = IMM_S;
         OP_BRANCH: imm_of = IMM_B;
         OP_LUI:    imm_of = IMM_U;
         OP_JAL:    imm_of = IMM_J;
         default:   imm_of = IMM_I;
      endcase
   endfunction

   function automatic logic src_of(input logic [6:0] op);
      src_of = !(op == OP_R || op == OP_BRANCH);
   endfunction

   function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_JAL: legal = 1'b1;
         OP_BRANCH: legal = !f3[1];
         default:   legal = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         br_q  <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (state == DECODE) begin
            op_q <= opcode;
            br_q <= {funct3[2], funct3[0]};
         end
      end
   end

   always_comb begin
      taken = br_q[1] ? (alu_lt ^ br_q[0]) : (alu_zero ^ br_q[0]);
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = 1'b0;
      imm_sel    = '0;
      alu_src_b  = 1'b0;
      reg_write  = 1'b0;
      wb_sel     = '0;
      fault      = 1'b0;

      case (state)
         IDLE: state_next = FETCH;
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               state_next = DECODE;
            end else if (cnt == WAIT_LAST) begin
               state_next = TRAP;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         DECODE: begin
            // Latched copy is not valid until the next cycle, so decode the IR directly.
            imm_sel    = imm_of(opcode);
            alu_src_b  = src_of(opcode);
            state_next = legal(opcode, funct3) ? EXEC : TRAP;
         end
         EXEC: begin
            imm_sel   = imm_of(op_q);
            alu_src_b = src_of(op_q);
            if (op_q == OP_BRANCH) begin
               pc_write   = 1'b1;
               pc_sel     = taken;
               state_next = FETCH;
            end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
               state_next = MEM;
            end else begin
               state_next = WB;
            end
         end
         MEM: begin
            imm_sel   = imm_of(op_q);
            alu_src_b = src_of(op_q);
            mem_req   = 1'b1;
            mem_we    = (op_q == OP_STORE);
            if (mem_ready) begin
               if (op_q == OP_STORE) begin
                  pc_write   = 1'b1;
                  state_next = FETCH;
               end else begin
                  state_next = WB;
               end
            end else if (cnt == WAIT_LAST) begin
               state_next = TRAP;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         WB: begin
            imm_sel    = imm_of(op_q);
            alu_src_b  = src_of(op_q);
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            pc_sel     = (op_q == OP_JAL);
            wb_sel     = (op_q == OP_LOAD) ? 2'd1 : (op_q == OP_JAL) ? 2'd2 : 2'd0;
            state_next = FETCH;
         end
         TRAP: fault = 1'b1;
         default: state_next = IDLE;
      endcase

      // Every state change starts a fresh wait window.
      if (state_next != state) cnt_next = '0;
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: per-instruction latency,
// control values and trap behaviour predicted from instruction-level rules.
module tb_multicycle_control;

   localparam int unsigned T = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       alu_zero, alu_lt, mem_ready;
   logic       mem_req, mem_we, ir_write, pc_write, pc_sel, alu_src_b, reg_write, fault;
   logic [2:0] imm_sel;
   logic [1:0] wb_sel;
   logic [12:0] outs;

   multicycle_control #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
      .pc_write(pc_write), .pc_sel(pc_sel), .imm_sel(imm_sel),
      .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_sel(wb_sel),
      .fault(fault)
   );

   always #5 clk = ~clk;

   assign outs = {mem_req, mem_we, ir_write, pc_write, pc_sel, imm_sel,
                  alu_src_b, reg_write, wb_sel, fault};

   typedef struct {
      bit trap;
      int cycles;
      int mem_cyc;
      bit we;
      int reg_cnt;
      int wb;
      bit pc_sel;
      int imm;
      bit src;
   } exp_t;

   exp_t expq[$];
   int   waitq[$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   function automatic bit is_mem_op(input logic [6:0] op);
      return op == 7'b0000011 || op == 7'b0100011;
   endfunction

   function automatic bit is_legal_op(input logic [6:0] op);
      return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 || op == 7'b0100011 ||
             op == 7'b1100011 || op == 7'b0110111 || op == 7'b1101111;
   endfunction

   // Instruction-level reference: latency and control effects from opcode and waits.
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input bit z,
                                  input bit lt, input int wf, input int wm);
      exp_t e;
      e = '{default: 0};
      if (wf >= int'(T)) begin
         e.trap = 1; e.cycles = T;
         return e;
      end
      case (op)
         7'b0110011: begin e.cycles = wf + 4; e.reg_cnt = 1; e.imm = 0; e.src = 0; end
         7'b0010011: begin e.cycles = wf + 4; e.reg_cnt = 1; e.imm = 0; e.src = 1; end
         7'b0110111: begin e.cycles = wf + 4; e.reg_cnt = 1; e.imm = 3; e.src = 1; end
         7'b1101111: begin
            e.cycles = wf + 4; e.reg_cnt = 1; e.imm = 4; e.src = 1; e.wb = 2; e.pc_sel = 1;
         end
         7'b1100011: begin
            e.imm = 2; e.src = 0; e.cycles = wf + 3;
            case (f3)
               3'b000: e.pc_sel = z;
               3'b001: e.pc_sel = !z;
               3'b100: e.pc_sel = lt;
               3'b101: e.pc_sel = !lt;
               default: begin e.trap = 1; e.cycles = wf + 2; end
            endcase
         end
         7'b0000011: begin
            e.imm = 0; e.src = 1;
            if (wm >= int'(T)) begin e.trap = 1; e.cycles = wf + 3 + T; end
            else begin
               e.cycles = wf + 5 + wm; e.mem_cyc = wm + 1; e.we = 0; e.reg_cnt = 1; e.wb = 1;
            end
         end
         7'b0100011: begin
            e.imm = 1; e.src = 1;
            if (wm >= int'(T)) begin e.trap = 1; e.cycles = wf + 3 + T; end
            else begin e.cycles = wf + 4 + wm; e.mem_cyc = wm + 1; e.we = 1; end
         end
         default: begin e.trap = 1; e.cycles = wf + 2; end
      endcase
      return e;
   endfunction

   task automatic score(input bit got_trap, input int cyc, input int memc, input bit we_or,
                        input bit we_and, input int regc, input int wb, input bit psel,
                        input int imm, input bit src, input bit stable, input bit fwe);
      exp_t e;
      if (expq.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_event: got trap=%0d after %0d cycles, expected none", got_trap, cyc);
         return;
      end
      e = expq.pop_front();
      check("kind_trap", got_trap, e.trap);
      if (got_trap != e.trap) return;
      check("cycles", cyc, e.cycles);
      if (e.trap) return;
      check("imm_sel", imm, e.imm);
      check("alu_src_b", src, e.src);
      check("decode_stable", stable, 1);
      check("fetch_mem_we", fwe, 0);
      check("pc_sel", psel, e.pc_sel);
      check("reg_write_cycles", regc, e.reg_cnt);
      check("wb_sel", wb, e.wb);
      check("mem_cycles", memc, e.mem_cyc);
      if (e.mem_cyc > 0) begin
         check("mem_we_any", we_or, e.we);
         check("mem_we_all", we_and, e.we);
      end
   endtask

   // Reactive memory: each access takes the next queued wait count; ready noise when idle.
   initial begin
      bit busy;
      int left;
      busy = 0; left = 0;
      mem_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            busy = 0; mem_ready = 1'b0;
         end else if (mem_req) begin
            if (!busy) begin
               busy = 1;
               left = (waitq.size() > 0) ? waitq.pop_front() : 1000;
            end
            if (left == 0) begin mem_ready = 1'b1; busy = 0; end
            else begin mem_ready = 1'b0; left--; end
         end else begin
            busy = 0;
            mem_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: accumulates one instruction's observable behaviour, scores at retire or trap.
   initial begin
      bit active, fetched, dec_pending, trapped, stable, we_or, we_and, fwe;
      int cyc, memc, regc, wb;
      logic [2:0] dimm;
      logic dsrc;
      active = 0; trapped = 0; fetched = 0; dec_pending = 0; stable = 1;
      we_or = 0; we_and = 1; fwe = 0; cyc = 0; memc = 0; regc = 0; wb = 0;
      dimm = '0; dsrc = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin active = 0; trapped = 0; continue; end
         if (trapped) continue;
         if (!active && mem_req) begin
            active = 1; cyc = 0; fetched = 0; dec_pending = 0; stable = 1;
            memc = 0; we_or = 0; we_and = 1; regc = 0; wb = 0; fwe = 0;
         end
         if (!active) continue;
         cyc++;
         if (fault) begin
            score(1, cyc - 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            trapped = 1; active = 0; done_cnt++;
            continue;
         end
         if (!fetched) begin
            if (mem_we) fwe = 1;
            if (ir_write) begin fetched = 1; dec_pending = 1; end
         end else if (dec_pending) begin
            dimm = imm_sel; dsrc = alu_src_b; dec_pending = 0;
         end else begin
            if (imm_sel !== dimm || alu_src_b !== dsrc) stable = 0;
            if (mem_req) begin
               memc++;
               we_or = we_or | mem_we;
               we_and = we_and & mem_we;
            end
         end
         if (reg_write) begin regc++; wb = wb_sel; end
         if (pc_write) begin
            score(0, cyc, memc, we_or, we_and, regc, wb, pc_sel, dimm, dsrc, stable, fwe);
            active = 0; done_cnt++;
         end
      end
   end

   task automatic setup(input logic [6:0] op, input logic [2:0] f3, input bit z, input bit lt,
                        input int wf, input int wm, input bit push_exp);
      opcode = op; funct3 = f3; alu_zero = z; alu_lt = lt;
      waitq.push_back(wf);
      if (is_mem_op(op)) waitq.push_back(wm);
      if (push_exp) expq.push_back(model(op, f3, z, lt, wf, wm));
   endtask

   task automatic wait_done(input int start);
      for (int i = 0; i < 400; i++) begin
         if (done_cnt != start) return;
         @(negedge clk); #2;
      end
      errors++;
      $display("FAIL done_timeout: got no retire or trap within 400 cycles, expected one");
      finish_run();
   endtask

   task automatic run(input logic [6:0] op, input logic [2:0] f3, input bit z, input bit lt,
                      input int wf, input int wm);
      int start;
      start = done_cnt;
      setup(op, f3, z, lt, wf, wm, 1);
      wait_done(start);
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      #1;
      check("reset_outputs_zero", outs, 0);
      waitq.delete();
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      #1;
      check("idle_outputs_zero", outs, 0);
      @(posedge clk); #1;
      check("fetch_after_idle", mem_req, 1);
   endtask

   task automatic trap_then_reset(input logic [6:0] op, input logic [2:0] f3, input int wf,
                                  input int wm, input bit hold);
      int bad;
      run(op, f3, 1'b0, 1'b0, wf, wm);
      if (hold) begin
         bad = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (outs !== 13'h1) bad++;
         end
         check("trap_hold_cycles_bad", bad, 0);
         #2;
      end
      assert_reset();
      check("scoreboard_drained", expq.size(), 0);
   endtask

   task automatic restart_with_addi();
      int start;
      start = done_cnt;
      setup(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0, 1);
      release_reset();
      wait_done(start);
   endtask

   initial begin
      int start, op_i, wf, wm, gotwe;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] ops[7];
      logic [2:0] br_f3[4];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111};
      br_f3 = '{3'b000, 3'b001, 3'b100, 3'b101};
      rst_n = 1'b0; opcode = '0; funct3 = '0; alu_zero = 1'b0; alu_lt = 1'b0;

      // Power-on reset, then first instruction straight out of IDLE
      #1 check("por_outputs_zero", outs, 0);
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      start = done_cnt;
      setup(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0, 1);
      release_reset();
      wait_done(start);

      // Directed cases
      run(7'b1100011, 3'b000, 1'b1, 1'b0, 0, 0);
      run(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
      run(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
      run(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0);
      run(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
      run(7'b0010011, 3'b000, 1'b0, 1'b0, T - 1, 0);
      run(7'b0100011, 3'b010, 1'b0, 1'b0, 0, T - 1);

      // Randomized legal instruction stream
      for (int n = 0; n < 150; n++) begin
         op_i = $urandom_range(0, 6);
         op = ops[op_i];
         f3 = (op == 7'b1100011) ? br_f3[$urandom_range(0, 3)] : 3'($urandom_range(0, 7));
         wf = ($urandom_range(0, 7) == 0) ? $urandom_range(0, T - 1) : $urandom_range(0, 2);
         wm = ($urandom_range(0, 7) == 0) ? $urandom_range(0, T - 1) : $urandom_range(0, 3);
         run(op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wf, wm);
      end

      // Trap paths, each cleared by reset
      trap_then_reset(7'b1111111, 3'b000, 0, 0, 1);
      restart_with_addi();
      trap_then_reset(7'b0010011, 3'b000, T, 0, 0);
      restart_with_addi();
      trap_then_reset(7'b0000011, 3'b010, 1, T, 1);
      restart_with_addi();
      trap_then_reset(7'b1100011, 3'b010, 0, 0, 0);
      restart_with_addi();
      for (int n = 0; n < 3; n++) begin
         do op = 7'($urandom_range(0, 127)); while (is_legal_op(op));
         trap_then_reset(op, 3'($urandom_range(0, 7)), $urandom_range(0, 2), 0, 0);
         restart_with_addi();
      end

      // Reset in the middle of a store's memory phase
      setup(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 8, 0);
      gotwe = 0;
      for (int i = 0; i < 50 && gotwe == 0; i++) begin
         @(negedge clk); #2;
         if (mem_we === 1'b1) gotwe = 1;
      end
      check("store_mem_phase_reached", gotwe, 1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_mem_req", mem_req, 0);
      check("abort_mem_we", mem_we, 0);
      waitq.delete();
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      restart_with_addi();
      run(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2);
      run(7'b0000011, 3'b010, 1'b0, 1'b0, 1, 0);

      check("scoreboard_empty_at_end", expq.size(), 0);
      finish_run();
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
      finish_run();
   end

endmodule
